// File: rtl/memory_loader_module.sv
// Loader that halts the CPU sequencer, borrows the shared bus and writes bytes
// into RAM via the MAR/RAM input enables, one byte per three cycles.
module memory_loader_module #(
  parameter int unsigned MEM_DEPTH    = 16,
  parameter int unsigned HALT_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_req,
  input  logic       cpu_idle,
  input  logic       wr_valid,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       cpu_halt,
  output logic       load_active,
  output logic       mai,
  output logic       mi,
  inout  wire  [7:0] bus,
  output logic       done,
  output logic       err,
  output logic [7:0] count
);

  localparam int unsigned DW     = 8;
  localparam int unsigned WAIT_W = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT_WAIT,
    S_READY,
    S_ADDR,
    S_DATA,
    S_RELEASE
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DW-1:0]     data_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [DW-1:0]     bus_q;
  logic              bus_oe;

  logic              wr_ready_d;
  logic              cpu_halt_d;
  logic              load_active_d;
  logic              mai_d;
  logic              mi_d;
  logic              done_d;
  logic              bus_oe_d;
  logic [DW-1:0]     bus_d;

  logic              addr_ok;
  logic              timeout;

  assign addr_ok = (32'(wr_addr) < MEM_DEPTH);
  assign timeout = (wait_cnt == WAIT_W'(HALT_TIMEOUT));

  // Outputs are registered copies of the decode of the upcoming state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wr_ready    <= 1'b0;
      cpu_halt    <= 1'b0;
      load_active <= 1'b0;
      mai         <= 1'b0;
      mi          <= 1'b0;
      done        <= 1'b0;
      bus_oe      <= 1'b0;
      bus_q       <= '0;
    end else begin
      state       <= state_next;
      wr_ready    <= wr_ready_d;
      cpu_halt    <= cpu_halt_d;
      load_active <= load_active_d;
      mai         <= mai_d;
      mi          <= mi_d;
      done        <= done_d;
      bus_oe      <= bus_oe_d;
      bus_q       <= bus_d;
    end
  end

  // Next state; a presented byte in READY wins over a falling load_req.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (load_req) state_next = S_HALT_WAIT;
      end
      S_HALT_WAIT: begin
        if (cpu_idle)       state_next = S_READY;
        else if (!load_req) state_next = S_RELEASE;
        else if (timeout)   state_next = S_RELEASE;
      end
      S_READY: begin
        if (wr_valid) begin
          if (addr_ok) state_next = S_ADDR;
        end else if (!load_req) begin
          state_next = S_RELEASE;
        end
      end
      S_ADDR:    state_next = S_DATA;
      S_DATA:    state_next = S_READY;
      S_RELEASE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Output decode of the state about to be entered.
  always_comb begin
    wr_ready_d    = 1'b0;
    cpu_halt_d    = 1'b0;
    load_active_d = 1'b0;
    mai_d         = 1'b0;
    mi_d          = 1'b0;
    done_d        = 1'b0;
    bus_oe_d      = 1'b0;
    bus_d         = '0;
    case (state_next)
      S_HALT_WAIT: begin
        cpu_halt_d = 1'b1;
      end
      S_READY: begin
        cpu_halt_d    = 1'b1;
        load_active_d = 1'b1;
        wr_ready_d    = 1'b1;
      end
      S_ADDR: begin
        cpu_halt_d    = 1'b1;
        load_active_d = 1'b1;
        mai_d         = 1'b1;
        bus_oe_d      = 1'b1;
        bus_d         = wr_addr;
      end
      S_DATA: begin
        cpu_halt_d    = 1'b1;
        load_active_d = 1'b1;
        mi_d          = 1'b1;
        bus_oe_d      = 1'b1;
        bus_d         = data_q;
      end
      S_RELEASE: begin
        cpu_halt_d = 1'b1;
        done_d     = 1'b1;
      end
      default: begin
        cpu_halt_d = 1'b0;
      end
    endcase
  end

  // Session datapath: captured byte, halt wait counter, sticky error, byte count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= '0;
      wait_cnt <= '0;
      err      <= 1'b0;
      count    <= '0;
    end else begin
      if (state == S_READY && wr_valid && addr_ok) data_q <= wr_data;

      if (state == S_HALT_WAIT) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                      wait_cnt <= '0;

      if (state == S_IDLE && load_req) begin
        err   <= 1'b0;
        count <= '0;
      end
      if (state == S_HALT_WAIT && !cpu_idle && load_req && timeout) err <= 1'b1;
      if (state == S_READY && wr_valid && !addr_ok)                  err <= 1'b1;
      if (state == S_DATA && count != 8'hFF) count <= count + 8'd1;
    end
  end

  assign bus = bus_oe ? bus_q : {DW{1'bz}};

endmodule
